// File: rtl/weight_loader_if.sv
// Bus bundle between the weight loader, its upstream weight stream and the
// downstream weight buffers.
`timescale 1ns/1ps
interface weight_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PE     = 4
);
  localparam int PW = $clog2(NUM_PE) + 1;

  logic                  start;
  logic [7:0]            kernel_size;
  logic [PW-1:0]         pe_count;
  // s_valid/s_data/s_ready: a word transfers on a rising edge where s_valid
  // and s_ready are both 1; s_data must hold while s_valid=1 and s_ready=0.
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic [NUM_PE-1:0]     wb_flush;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, kernel_size, pe_count, s_valid, s_data,
    input  s_ready, wb_flush, wb_data, busy, done, err
  );

  modport slave (
    input  start, kernel_size, pe_count, s_valid, s_data,
    output s_ready, wb_flush, wb_data, busy, done, err
  );
endinterface

// File: rtl/weight_loader.sv
// Stages K weights per PE from a valid/ready stream, then flushes and streams
// them to each PE buffer in turn. WEIGHT_LOADER_CFG_CHECK_EN rejects bad configs.
`timescale 1ns/1ps
module weight_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PE     = 4,
  parameter int MAX_KERNEL = 16
) (
  input  logic             clk,
  input  logic             rst,
  weight_loader_if.slave   bus,
  output logic [2:0]       dbg_state
);
  localparam int PW = $clog2(NUM_PE) + 1;
  localparam int SW = (MAX_KERNEL > 1) ? $clog2(MAX_KERNEL) : 1;
  localparam logic [7:0]    MAX_K8   = 8'(MAX_KERNEL);
  localparam logic [PW-1:0] NUM_PE_P = PW'(NUM_PE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_FLUSH  = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [7:0]            cnt, rd, k_reg, k_last, k_eff;
  logic [PW-1:0]         idx, p_reg, p_last, p_eff;
  logic                  err_reg, cfg_ok, beat, more_pe;
  logic [DATA_WIDTH-1:0] staging [MAX_KERNEL];

  // Config sanitising: either reject outright or clamp into range.
  always_comb begin
`ifdef WEIGHT_LOADER_CFG_CHECK_EN
    cfg_ok = (bus.kernel_size != 8'd0) && (bus.kernel_size <= MAX_K8) &&
             (bus.pe_count != '0) && (bus.pe_count <= NUM_PE_P);
    k_eff  = bus.kernel_size;
    p_eff  = bus.pe_count;
`else
    cfg_ok = 1'b1;
    k_eff  = bus.kernel_size;
    if (bus.kernel_size == 8'd0)       k_eff = 8'd1;
    else if (bus.kernel_size > MAX_K8) k_eff = MAX_K8;
    p_eff  = bus.pe_count;
    if (bus.pe_count == '0)            p_eff = PW'(1);
    else if (bus.pe_count > NUM_PE_P)  p_eff = NUM_PE_P;
`endif
  end

  assign k_last  = k_reg - 8'd1;
  assign p_last  = p_reg - PW'(1);
  assign more_pe = (idx < p_last);
  assign beat    = bus.s_valid && (state == S_FILL);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.s_ready  = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.wb_flush = '0;
    bus.wb_data  = '0;
    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start && cfg_ok) state_next = S_FILL;
      end
      S_FILL: begin
        bus.s_ready = 1'b1;
        if (beat && (cnt == k_last)) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        bus.wb_flush = {{(NUM_PE-1){1'b0}}, 1'b1} << idx;
        state_next   = S_STREAM;
      end
      S_STREAM: begin
        bus.wb_data = staging[rd[SW-1:0]];
        if (rd == k_last) state_next = more_pe ? S_FILL : S_DONE;
      end
      S_DONE: begin
        bus.done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 8'd0;
      rd      <= 8'd0;
      idx     <= '0;
      k_reg   <= 8'd0;
      p_reg   <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (cfg_ok) begin
              k_reg <= k_eff;
              p_reg <= p_eff;
              idx   <= '0;
              cnt   <= 8'd0;
            end
`ifdef WEIGHT_LOADER_CFG_CHECK_EN
            else begin
              err_reg <= 1'b1;
            end
`endif
          end
        end
        S_FILL:  if (beat) cnt <= cnt + 8'd1;
        S_FLUSH: rd <= 8'd0;
        S_STREAM: begin
          rd <= rd + 8'd1;
          if ((rd == k_last) && more_pe) begin
            idx <= idx + PW'(1);
            cnt <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Staging RAM holds stale weights across reset; every load overwrites it.
  always_ff @(posedge clk) begin
    if (!rst && beat) staging[cnt[SW-1:0]] <= bus.s_data;
  end

  assign bus.err   = err_reg;
  assign dbg_state = state;
endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: a reference model queues the expected
// flush/stream sequence, a monitor checks it as the DUT produces it.
`timescale 1ns/1ps
module tb_weight_loader;
  localparam int DW   = 16;
  localparam int NPE  = 4;
  localparam int MAXK = 16;
  localparam int PW   = $clog2(NPE) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  weight_loader_if #(.DATA_WIDTH(DW), .NUM_PE(NPE)) bus ();

  weight_loader #(.DATA_WIDTH(DW), .NUM_PE(NPE), .MAX_KERNEL(MAXK)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NPE-1:0] flush;
    int             k;
    bit             last;
  } seg_t;

  seg_t          seg_q[$];
  logic [DW-1:0] exp_q[$];
  int n_checks = 0, n_fail = 0;
  int done_seen = 0, beats_seen = 0, fill_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected sequence whenever the DUT drives a flush/stream.
  initial begin : monitor
    int stream_left;
    bit last_seg, done_due;
    seg_t s;
    logic [DW-1:0] e;
    stream_left = 0; last_seg = 0; done_due = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seg_q.delete();
        exp_q.delete();
        stream_left = 0;
        done_due    = 0;
      end else begin
        if (bus.s_ready) fill_cycles++;
        if (bus.s_valid && bus.s_ready) beats_seen++;
        if (bus.done) done_seen++;
        if (stream_left > 0) begin
          if (exp_q.size() == 0) chk("stream_underflow", 32'(exp_q.size()), 1);
          else begin
            e = exp_q.pop_front();
            chk("stream_data", 32'(bus.wb_data), 32'(e));
          end
          chk("flush_in_stream", 32'(bus.wb_flush), 0);
          stream_left--;
          if (stream_left == 0 && last_seg) done_due = 1;
        end else if (done_due) begin
          chk("done_pulse", 32'(bus.done), 1);
          chk("data_in_done", 32'(bus.wb_data), 0);
          done_due = 0;
        end else if (bus.wb_flush != '0) begin
          if (seg_q.size() == 0) chk("unexpected_flush", 32'(bus.wb_flush), 0);
          else begin
            s = seg_q.pop_front();
            chk("flush_onehot", 32'(bus.wb_flush), 32'(s.flush));
            stream_left = s.k;
            last_seg    = s.last;
          end
          chk("data_in_flush", 32'(bus.wb_data), 0);
        end else begin
          chk("wb_data_quiet", 32'(bus.wb_data), 0);
          chk("done_stray", 32'(bus.done), 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: effective K/P and whether the start is accepted.
  function automatic void model(input int k, input int p, output int keff,
                                output int peff, output bit accept);
`ifdef WEIGHT_LOADER_CFG_CHECK_EN
    accept = (k >= 1) && (k <= MAXK) && (p >= 1) && (p <= NPE);
    keff = k;
    peff = p;
`else
    accept = 1;
    keff = (k == 0) ? 1 : ((k > MAXK) ? MAXK : k);
    peff = (p == 0) ? 1 : ((p > NPE) ? NPE : p);
`endif
  endfunction

  task automatic do_start(input int k, input int p);
    tick();
    bus.start       = 1'b1;
    bus.kernel_size = 8'(k);
    bus.pe_count    = PW'(p);
    tick();
    bus.start       = 1'b0;
  endtask

  // mode 0: back-to-back, 1: random gaps, 2: one idle cycle before each word.
  task automatic feed(input logic [DW-1:0] words[$], input int mode);
    bit hs;
    foreach (words[i]) begin
      if (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0)) begin
        bus.s_valid = 1'b0;
        repeat ((mode == 1) ? $urandom_range(1, 3) : 1) tick();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = words[i];
      hs = 0;
      for (int t = 0; t < 300 && !hs; t++) begin
        @(negedge clk);
        hs = bus.s_ready;
        tick();
      end
      if (!hs) begin
        chk("feed_timeout", 32'(hs), 1);
        bus.s_valid = 1'b0;
        return;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("idle_timeout", 32'(bus.busy), 0);
  endtask

  function automatic void build(input int keff, input int peff, input int base,
                                output logic [DW-1:0] words[$]);
    seg_t s;
    logic [DW-1:0] w;
    words.delete();
    for (int pe = 0; pe < peff; pe++) begin
      s.flush = NPE'(1) << pe;
      s.k     = keff;
      s.last  = (pe == peff - 1);
      seg_q.push_back(s);
      for (int j = 0; j < keff; j++) begin
        w = (base >= 0) ? DW'(base + pe * keff + j) : DW'($urandom);
        exp_q.push_back(w);
        words.push_back(w);
      end
    end
  endfunction

  task automatic run_load(input int k, input int p, input int mode, input bit poke,
                          input int base);
    int keff, peff, d0, b0;
    bit accept;
    logic [DW-1:0] words[$];
    model(k, p, keff, peff, accept);
    build(keff, peff, base, words);
    d0 = done_seen;
    b0 = beats_seen;
    do_start(k, p);
    feed(words, mode);
    if (poke) begin
      tick();
      bus.start       = 1'b1;
      bus.kernel_size = 8'd2;
      bus.pe_count    = PW'(1);
      tick();
      bus.start       = 1'b0;
    end
    wait_idle();
    chk("done_count", 32'(done_seen - d0), 1);
    chk("beats_accepted", 32'(beats_seen - b0), 32'(keff * peff));
    chk("sb_drained", 32'(seg_q.size() + exp_q.size()), 0);
    chk("err_clear", 32'(bus.err), 0);
  endtask

  initial begin : stimulus
    logic [DW-1:0] words[$];
    int keff, peff;
    bit accept;
    rst = 1'b1;
    bus.start = 1'b0; bus.kernel_size = 8'd0; bus.pe_count = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_wb_flush", 32'(bus.wb_flush), 0);
    chk("rst_wb_data", 32'(bus.wb_data), 0);
    tick();
    rst = 1'b0;

    run_load(3, 2, 0, 0, 'h11);

    fill_cycles = 0;
    run_load(4, 1, 2, 0, 'hA0);
    chk("fill_cycles_toggle", 32'(fill_cycles), 8);

    run_load(4, 2, 0, 1, -1);

    // Reset on the second stream cycle, then a clean load.
    model(3, 1, keff, peff, accept);
    build(keff, peff, -1, words);
    do_start(3, 1);
    feed(words, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_wb_data", 32'(bus.wb_data), 0);
    chk("midrst_wb_flush", 32'(bus.wb_flush), 0);
    chk("midrst_s_ready", 32'(bus.s_ready), 0);
    run_load(3, 2, 0, 0, 'h11);

`ifdef WEIGHT_LOADER_CFG_CHECK_EN
    do_start(0, 2);
    repeat (4) begin
      @(negedge clk);
      chk("bad_cfg_busy", 32'(bus.busy), 0);
      chk("bad_cfg_err", 32'(bus.err), 1);
    end
    do_start(20, 1);
    @(negedge clk);
    chk("bad_k_busy", 32'(bus.busy), 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("err_rst_clear", 32'(bus.err), 0);
`else
    run_load(20, 2, 0, 0, -1);
    run_load(0, 0, 0, 0, -1);
    run_load(5, 7, 1, 0, -1);
`endif

    run_load(16, 4, 1, 0, -1);
    run_load(1, 4, 0, 0, -1);

    for (int it = 0; it < 15; it++)
      run_load($urandom_range(1, MAXK), $urandom_range(1, NPE), $urandom_range(0, 1), 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, weight word width.
REQ-002 SHALL have parameter NUM_PE, default 4, number of downstream weight buffers served.
REQ-003 SHALL have parameter MAX_KERNEL, default 16, staging depth (equals downstream buffer depth).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to load all PEs.
REQ-007 kernel_size  input  8  words per PE, sampled on accepted start.
REQ-008 pe_count  input  $clog2(NUM_PE)+1  PEs to load (1..NUM_PE), sampled on accepted start.
REQ-009 s_valid / s_data / s_ready  input 1 / input DATA_WIDTH / output 1  upstream weight stream, valid/ready.
REQ-010 wb_flush  output  NUM_PE  one-hot flush pulse to target weight buffer.
REQ-011 wb_data  output  DATA_WIDTH  shared data bus to all weight buffers.
REQ-012 busy / done / err  output 1 each  load in progress / one-cycle completion pulse / sticky config error.

Function
REQ-013 States: IDLE, FILL, FLUSH, STREAM, DONE.
REQ-014 IDLE: start=1 with valid config -> FILL, latch kernel_size (K), pe_count (P), PE index=0; start ignored in any other state.
REQ-015 FILL: s_ready=1; each s_valid&s_ready beat writes s_data to staging[cnt], cnt++; after K-th beat -> FLUSH; s_ready=0 in all other states.
REQ-016 FLUSH: exactly one cycle, wb_flush[idx]=1, all other bits 0; -> STREAM with rd=0.
REQ-017 STREAM: wb_data=staging[rd] in stream cycle rd (first stream cycle is the cycle after the flush pulse), K consecutive cycles, no stall or gap.
REQ-018 After stream cycle K-1: idx<P-1 -> idx++, cnt=0, FILL; else -> DONE.
REQ-019 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-020 busy=1 in FILL, FLUSH, STREAM, DONE; 0 in IDLE.
REQ-021 wb_data=0 outside STREAM; wb_flush=0 outside FLUSH.
REQ-022 Upstream stalls (s_valid=0) in FILL only extend FILL; never affect an in-progress STREAM.
REQ-023 K=1: FILL takes one beat, STREAM one cycle; K=MAX_KERNEL fills staging exactly without wrap.
REQ-024 Counters cnt, rd SHALL be 8 bits; comparisons against K-1 computed in 8 bits.

Reset
REQ-025 rst=1 at any clock edge, including mid-FILL or mid-STREAM, SHALL force IDLE, cnt=rd=idx=0, busy=done=err=0, s_ready=0, wb_flush=0, wb_data=0.
REQ-026 Staging contents need not be cleared by reset.

Configuration
REQ-027 Macro WEIGHT_LOADER_CFG_CHECK_EN selects config checking.
REQ-028 Defined: start with K=0, K>MAX_KERNEL, pe_count=0 or pe_count>NUM_PE is rejected (stay IDLE) and sets err=1 until rst.
REQ-029 Not defined: err tied 0; K>MAX_KERNEL saturates to MAX_KERNEL, K=0 treated as 1, pe_count=0 treated as 1, pe_count>NUM_PE saturates to NUM_PE.

Verification
REQ-030 K=3, P=2, stream 0x11..0x16 back-to-back -> flush[0] pulse, wb_data 0x11,0x12,0x13; flush[1], 0x14,0x15,0x16; done one cycle after last word.
REQ-031 K=4, P=1, s_valid toggled every other cycle -> FILL lasts 8 cycles; STREAM still 4 contiguous cycles 0xA0..0xA3.
REQ-032 start asserted again during STREAM -> ignored, exactly one done pulse.
REQ-033 rst pulsed on 2nd STREAM cycle -> next cycle busy=0, wb_data=0, wb_flush=0; new start runs clean.
REQ-034 Macro defined, start with K=0 -> busy stays 0, err=1 and holds; macro undefined, K=20 -> 16 beats accepted per PE, err=0.
REQ-035 K=16, P=4, with weight buffers attached -> each buffer holds its 16 words in order.
